pixel_stream_out: RTL and testbench
===================================

# pixel_stream_out

Downstream stage of the pixel output state machine. Accepts one computed pixel (RGB plus screen coordinates) per `wen`/`ready` handshake, buffers it in a small FIFO and emits it as an AXI4-Stream video stream with start-of-frame (`m_tuser`) and end-of-line (`m_tlast`) markers for the VDMA/frame-buffer path. It also checks that pixels arrive in raster order and counts frames delivered downstream.

## Interface
- `WIDTH`, 640: pixels per line.
- `HEIGHT`, 480: lines per frame.
- `DEPTH`, 4: FIFO entries; must be a power of 2 and at least 2.

- `aclk`  in  1  single clock; all logic is on its rising edge.
- `areset`  in  1  asynchronous, active-high reset.
- `wen`  in  1  upstream pixel valid, held until accepted.
- `rgb_in`  in  24  pixel colour, {R,G,B}.
- `x_in`  in  10  pixel column.
- `y_in`  in  10  pixel row.
- `ready`  out  1  block can accept; a transfer occurs when `wen && ready`.
- `m_tdata`  out  24  stream pixel data.
- `m_tvalid`  out  1  stream valid.
- `m_tready`  in  1  downstream ready.
- `m_tuser`  out  1  SOF; high on the pixel with x=0, y=0.
- `m_tlast`  out  1  EOL; high on the pixel with x=WIDTH-1.
- `seq_err`  out  1  sticky raster-order / range error.
- `frame_count`  out  16  frames fully delivered downstream; wraps modulo 2^16.

## Operation
- **FIFO.** DEPTH entries of {eol, sof, rgb}, 26 bits each. Read is show-ahead: the head entry drives `m_tdata`, `m_tuser` and `m_tlast`. The occupancy counter is clog2(DEPTH)+1 bits wide.
- **ready.** `ready = run && (count < DEPTH)`. `run` is a flop cleared by reset and set on the first `aclk` edge after `areset` falls. `ready` never depends on `m_tready` in the same cycle.
- **Accept** (`wen && ready`):
  - If `x_in < WIDTH` and `y_in < HEIGHT`, push {`x_in==WIDTH-1`, `x_in==0 && y_in==0`, `rgb_in`}.
  - Otherwise the handshake still completes, nothing is pushed, and `seq_err` is set.
- **Order check.** Expected counters `exp_x` and `exp_y` reset to 0.
  - On each in-range accept, if (`x_in`,`y_in`) differs from (`exp_x`,`exp_y`), set `seq_err`. The pixel is still pushed, with flags taken from the incoming coordinates.
  - The counters are then reloaded from the incoming coordinate, not from the old expected value: `exp_x = x_in+1`. If `x_in == WIDTH-1`, instead `exp_x = 0` and `exp_y = y_in+1`, with `exp_y` wrapping to 0 after HEIGHT-1.
- **seq_err.** Once set, it is cleared only by `areset`.
- **Output.** `m_tvalid = (count != 0)`. Pop occurs on `m_tvalid && m_tready`. While `m_tvalid` is 0, `m_tdata`, `m_tuser` and `m_tlast` are forced to 0.
- **frame_count.** Increments by 1 on a pop whose entry has eol=1 and came from row HEIGHT-1. A last-row flag is stored per entry, making entries 27 bits.
- **Simultaneous push and pop:**
  - Not empty and not full: count unchanged; write and read pointers both advance.
  - Empty: no pop this cycle, the pixel is pushed, and `m_tvalid` rises next cycle.
  - Full: `ready` is 0 that cycle, so there is no push; the pop frees a slot and `ready` rises next cycle.
- **Reset mid-operation.** FIFO contents are discarded. Pointers, count, `exp_x`, `exp_y`, `seq_err`, `frame_count` and `run` all clear asynchronously. Any upstream pixel held during reset is accepted only once `ready` returns.

## Timing
- **Reset values:** `ready`=0, `m_tvalid`=0, `m_tdata`=0, `m_tuser`=0, `m_tlast`=0, `seq_err`=0, `frame_count`=0.
- **Latency.** Accept at edge N puts the pixel on the stream (`m_tvalid`=1) after edge N when the FIFO was empty: one cycle input-to-output.
- **Throughput.** One pixel per cycle when `m_tready` is held high.
- **Full case.** With `m_tready`=0, exactly DEPTH pixels are accepted; then `ready`=0 until one pop has occurred.
- **AXI-Stream rule.** While `m_tvalid` is 1 and `m_tready` is 0, `m_tdata`, `m_tuser` and `m_tlast` are held stable.
- **Output timing.** `seq_err` and `frame_count` update on the edge that performs the triggering accept or pop.

## Test plan
- **Reset and first pixel.** Release reset with `wen`=1, rgb=0x123456, (0,0). Required: `ready`=0 in the first cycle. The pixel is then accepted, followed one cycle later by `m_tvalid`=1, `m_tdata`=0x123456 and `m_tuser`=1.
- **Backpressure.** Hold `m_tready`=0 and stream 6 pixels. Required: exactly 4 accepted, `ready`=0 after the 4th, and `m_tdata` stable. Raising `m_tready` drains the pixels in order with no loss or duplication.
- **Full frame, small geometry.** Use WIDTH=4, HEIGHT=2 with continuous `m_tready`=1. Required: `m_tlast` on pixels 3 and 7, `m_tuser` only on pixel 0, `frame_count` 0→1 on the pop of pixel 7, and `seq_err`=0.
- **Order error.** Send (0,0), (2,0), (3,0). Required: `seq_err`=1 after the second accept. All three pixels are output, with `m_tlast` on (3,0). `seq_err` stays 1 until reset.
- **Out of range.** Send x=WIDTH. Required: handshake completes, nothing is output, and `seq_err`=1.
- **Reset mid-stream.** Assert `areset` with 3 pixels buffered. Required: `m_tvalid` and the other outputs go to 0 asynchronously, and after release the FIFO is empty.

Source files
------------

// File: rtl/pixel_stream_out.sv
// Pixel output stage: buffers raster pixels in a show-ahead FIFO and emits them as an
// AXI4-Stream video stream with SOF/EOL markers, raster-order checking and a frame counter.
module pixel_stream_out #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int DEPTH  = 4
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        wen,
  input  logic [23:0] rgb_in,
  input  logic [9:0]  x_in,
  input  logic [9:0]  y_in,
  output logic        ready,
  output logic [23:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tuser,
  output logic        m_tlast,
  output logic        seq_err,
  output logic [15:0] frame_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [10:0]   W_LIM  = 11'(WIDTH);
  localparam logic [10:0]   H_LIM  = 11'(HEIGHT);
  localparam logic [9:0]    X_LAST = 10'(WIDTH - 1);
  localparam logic [9:0]    Y_LAST = 10'(HEIGHT - 1);

  // entry layout: {last_row, eol, sof, rgb}
  logic [26:0]   mem [DEPTH];
  logic [26:0]   head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [9:0]    exp_x;
  logic [9:0]    exp_y;
  logic          run;
  logic          accept;
  logic          in_range;
  logic          push;
  logic          pop;

  assign ready    = run && (count < FULL);
  assign accept   = wen && ready;
  assign in_range = ({1'b0, x_in} < W_LIM) && ({1'b0, y_in} < H_LIM);
  assign push     = accept && in_range;

  assign head     = mem[rd_ptr];
  assign m_tvalid = (count != '0);
  assign pop      = m_tvalid && m_tready;
  assign m_tdata  = m_tvalid ? head[23:0] : 24'd0;
  assign m_tuser  = m_tvalid && head[24];
  assign m_tlast  = m_tvalid && head[25];

  always_ff @(posedge aclk) begin
    if (push)
      mem[wr_ptr] <= {y_in == Y_LAST, x_in == X_LAST, (x_in == 10'd0) && (y_in == 10'd0), rgb_in};
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Expected position follows the incoming pixel, so one glitch flags once and resyncs.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      exp_x   <= '0;
      exp_y   <= '0;
      seq_err <= 1'b0;
    end else begin
      if (accept && !in_range)
        seq_err <= 1'b1;
      if (push) begin
        if ((x_in != exp_x) || (y_in != exp_y))
          seq_err <= 1'b1;
        if (x_in == X_LAST) begin
          exp_x <= '0;
          exp_y <= (y_in == Y_LAST) ? 10'd0 : y_in + 10'd1;
        end else begin
          exp_x <= x_in + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      frame_count <= '0;
    end else if (pop && head[25] && head[26]) begin
      frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pixel_stream_out.sv
// Directed bench for pixel_stream_out on a 4x2 frame with a 4-entry FIFO; a negedge
// monitor scoreboards every accepted pixel against the stream output.
module tb_pixel_stream_out;
  localparam int W = 4;
  localparam int H = 2;
  localparam int D = 4;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        wen = 1'b0;
  logic [23:0] rgb_in = '0;
  logic [9:0]  x_in = '0;
  logic [9:0]  y_in = '0;
  logic        m_tready = 1'b0;
  logic        ready;
  logic [23:0] m_tdata;
  logic        m_tvalid;
  logic        m_tuser;
  logic        m_tlast;
  logic        seq_err;
  logic [15:0] frame_count;

  int total = 0;
  int bad = 0;
  int pops = 0;
  int tlast_cnt = 0;
  int tuser_cnt = 0;
  logic [26:0] sb [$];
  logic        hold_prev = 1'b0;
  logic [25:0] prev_out = '0;

  pixel_stream_out #(.WIDTH(W), .HEIGHT(H), .DEPTH(D)) dut (
    .aclk(aclk), .areset(areset), .wen(wen), .rgb_in(rgb_in), .x_in(x_in), .y_in(y_in),
    .ready(ready), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tuser(m_tuser), .m_tlast(m_tlast), .seq_err(seq_err), .frame_count(frame_count)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: pushes expectations on accept, pops and compares on stream handshake.
  always @(negedge aclk) begin
    if (areset) begin
      hold_prev = 1'b0;
      sb.delete();
    end else begin
      if (hold_prev) begin
        check("hold_valid", {31'd0, m_tvalid}, 32'd1);
        check("hold_data", {6'd0, m_tlast, m_tuser, m_tdata}, {6'd0, prev_out});
      end
      if (wen && ready && int'(x_in) < W && int'(y_in) < H)
        sb.push_back({y_in == 10'(H-1), x_in == 10'(W-1), x_in == 10'd0 && y_in == 10'd0, rgb_in});
      if (m_tvalid && m_tready) begin
        check("sb_not_empty", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          logic [26:0] e;
          e = sb.pop_front();
          check("pop_data", {8'd0, m_tdata}, {8'd0, e[23:0]});
          check("pop_tuser", {31'd0, m_tuser}, {31'd0, e[24]});
          check("pop_tlast", {31'd0, m_tlast}, {31'd0, e[25]});
        end
        pops++;
        if (m_tlast) tlast_cnt++;
        if (m_tuser) tuser_cnt++;
      end
      hold_prev = m_tvalid && !m_tready;
      prev_out  = {m_tlast, m_tuser, m_tdata};
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accept edge (or after the budget).
  task automatic send(input logic [23:0] rgb, input int x, input int y, input int budget,
                      output bit ok);
    rgb_in = rgb;
    x_in   = 10'(x);
    y_in   = 10'(y);
    wen    = 1'b1;
    ok     = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge aclk);
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge aclk);
    #1;
    wen = 1'b0;
  endtask

  task automatic send_ok(input logic [23:0] rgb, input int x, input int y);
    bit ok;
    send(rgb, x, y, 8, ok);
    check($sformatf("accept_%0d_%0d", x, y), {31'd0, ok}, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    @(negedge aclk);
    @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] bp [6];
    bit ok;

    // reset with a pixel already waiting upstream
    areset = 1'b1; wen = 1'b1; rgb_in = 24'h123456; x_in = 10'd0; y_in = 10'd0; m_tready = 1'b0;
    #12;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_tdata", {8'd0, m_tdata}, 32'd0);
    check("rst_tuser", {31'd0, m_tuser}, 32'd0);
    check("rst_tlast", {31'd0, m_tlast}, 32'd0);
    check("rst_seq_err", {31'd0, seq_err}, 32'd0);
    check("rst_frame_count", {16'd0, frame_count}, 32'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    check("ready_first_cycle", {31'd0, ready}, 32'd0);
    send_ok(24'h123456, 0, 0);
    @(negedge aclk);
    check("first_tvalid", {31'd0, m_tvalid}, 32'd1);
    check("first_tdata", {8'd0, m_tdata}, 32'h123456);
    check("first_tuser", {31'd0, m_tuser}, 32'd1);
    @(posedge aclk);
    #1;
    m_tready = 1'b1;
    idle(2);
    check("drained_first", {31'd0, m_tvalid}, 32'd0);

    // backpressure: four fit, the fifth waits
    m_tready = 1'b0;
    for (int i = 0; i < 6; i++) bp[i] = 24'($urandom());
    send_ok(bp[0], 1, 0);
    send_ok(bp[1], 2, 0);
    send_ok(bp[2], 3, 0);
    send_ok(bp[3], 0, 1);
    check("full_ready", {31'd0, ready}, 32'd0);
    check("full_head", {8'd0, m_tdata}, {8'd0, bp[0]});
    send(bp[4], 1, 1, 4, ok);
    check("fifth_blocked", {31'd0, ok}, 32'd0);
    check("full_head_stable", {8'd0, m_tdata}, {8'd0, bp[0]});
    m_tready = 1'b1;
    send_ok(bp[4], 1, 1);
    send_ok(bp[5], 2, 1);
    send_ok(24'($urandom()), 3, 1);
    idle(6);
    check("bp_pops", pops, 8);
    check("bp_sb_empty", sb.size(), 0);
    check("frame1_count", {16'd0, frame_count}, 32'd1);
    check("frame1_seq_err", {31'd0, seq_err}, 32'd0);

    // continuous full frame
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        send_ok(24'($urandom()), x, y);
    idle(4);
    check("frame2_count", {16'd0, frame_count}, 32'd2);
    check("frame2_seq_err", {31'd0, seq_err}, 32'd0);
    check("frame2_pops", pops, 16);
    check("frame2_tlast_cnt", tlast_cnt, 4);
    check("frame2_tuser_cnt", tuser_cnt, 2);

    // raster order error
    send_ok(24'hAA0000, 0, 0);
    check("order_seq_err_0", {31'd0, seq_err}, 32'd0);
    send_ok(24'hBB0000, 2, 0);
    check("order_seq_err_1", {31'd0, seq_err}, 32'd1);
    send_ok(24'hCC0000, 3, 0);
    idle(4);
    check("order_pops", pops, 19);
    check("order_tlast_cnt", tlast_cnt, 5);
    check("order_tuser_cnt", tuser_cnt, 3);
    check("order_seq_err_sticky", {31'd0, seq_err}, 32'd1);

    do_reset();
    check("rst2_seq_err", {31'd0, seq_err}, 32'd0);
    check("rst2_frame_count", {16'd0, frame_count}, 32'd0);

    // out-of-range column
    send_ok(24'hDEAD00, W, 0);
    idle(3);
    check("oor_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("oor_pops", pops, 19);
    check("oor_seq_err", {31'd0, seq_err}, 32'd1);

    do_reset();

    // reset with three pixels buffered
    m_tready = 1'b0;
    send_ok(24'h010101, 0, 0);
    send_ok(24'h020202, 1, 0);
    send_ok(24'h030303, 2, 0);
    check("mid_tvalid_before", {31'd0, m_tvalid}, 32'd1);
    @(negedge aclk);
    #2;
    areset = 1'b1;
    #1;
    check("mid_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("mid_tdata", {8'd0, m_tdata}, 32'd0);
    check("mid_tuser", {31'd0, m_tuser}, 32'd0);
    check("mid_ready", {31'd0, ready}, 32'd0);
    @(negedge aclk);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    idle(3);
    check("mid_empty_after", {31'd0, m_tvalid}, 32'd0);
    m_tready = 1'b1;
    send_ok(24'h0F0F0F, 0, 0);
    idle(3);
    check("mid_pops", pops, 20);
    check("mid_tuser_cnt", tuser_cnt, 4);
    check("mid_sb_empty", sb.size(), 0);
    check("mid_seq_err", {31'd0, seq_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
